// File: rtl/mips_boot_ctrl.sv
// Load/run/dump sequencer for the pipe_MIPS32 core: streams a program into memory,
// initialises the register file, releases the core and streams a memory window back out.
module mips_boot_ctrl #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int NUM_REGS       = 32,
  parameter int REG_INIT_MODE  = 1,
  parameter int PC_RESET       = 0,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              reg_we,
  output logic [4:0]        reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              core_hold,
  output logic              core_pc_load,
  output logic [ADDR_W-1:0] core_pc,
  input  logic              core_halted,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W-1:0] dump_len,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REGINIT, S_PCLOAD, S_RUN, S_DUMP_RD, S_DUMP_OUT, S_DONE
  } state_t;

  state_t            state, state_next;
  logic [5:0]        k;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] base, len, idx, idx_next;
  logic [DATA_W-1:0] data_q;
  logic              cap;
  logic              timeout_q;
  logic              last_reg, count_max;

  assign idx_next  = idx + 1'b1;
  assign last_reg  = (k == 6'(NUM_REGS - 1));
  assign count_max = (count == CNT_W'(TIMEOUT_CYCLES - 1));
  assign core_pc   = ADDR_W'(PC_RESET);
  assign timeout   = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start) state_next = S_LOAD;
      S_LOAD:     if (load_valid && load_last) state_next = S_REGINIT;
      S_REGINIT:  if (last_reg) state_next = S_PCLOAD;
      S_PCLOAD:   state_next = S_RUN;
      S_RUN: begin
        if (core_halted)    state_next = S_DUMP_RD;
        else if (count_max) state_next = S_DONE;
      end
      S_DUMP_RD:  state_next = (len == '0) ? S_DONE : S_DUMP_OUT;
      S_DUMP_OUT: if (dump_ready) state_next = (idx_next == len) ? S_DONE : S_DUMP_RD;
      S_DONE:     if (start) state_next = S_LOAD;
      default:    state_next = S_IDLE;
    endcase
  end

  // The first valid cycle forwards mem_rdata directly (cap=1) and latches it, so a
  // stalled word stays stable and an unstalled dump sustains one word per two cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k         <= '0;
      count     <= '0;
      base      <= '0;
      len       <= '0;
      idx       <= '0;
      data_q    <= '0;
      cap       <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        S_LOAD:    k <= '0;
        S_REGINIT: k <= k + 1'b1;
        S_PCLOAD:  count <= '0;
        S_RUN: begin
          count <= count + 1'b1;
          if (core_halted) begin
            base <= dump_base;
            len  <= dump_len;
            idx  <= '0;
          end else if (count_max) begin
            timeout_q <= 1'b1;
          end
        end
        S_DUMP_RD: cap <= (len != '0);
        S_DUMP_OUT: begin
          if (cap) begin
            data_q <= mem_rdata;
            cap    <= 1'b0;
          end
          if (dump_ready) idx <= idx_next;
        end
        S_DONE: if (start) timeout_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    load_ready   = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    reg_we       = 1'b0;
    reg_addr     = '0;
    reg_wdata    = '0;
    core_hold    = 1'b1;
    core_pc_load = 1'b0;
    dump_valid   = 1'b0;
    dump_data    = '0;
    dump_last    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      S_IDLE: busy = 1'b0;
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_addr  = load_addr;
          mem_wdata = load_data;
        end
      end
      S_REGINIT: begin
        reg_we    = 1'b1;
        reg_addr  = k[4:0];
        reg_wdata = (REG_INIT_MODE != 0) ? DATA_W'(k) : '0;
      end
      S_PCLOAD: core_pc_load = 1'b1;
      S_RUN:    core_hold = 1'b0;
      S_DUMP_RD: begin
        if (len != '0) begin
          mem_re   = 1'b1;
          mem_addr = base + idx;
        end
      end
      S_DUMP_OUT: begin
        dump_valid = 1'b1;
        dump_data  = cap ? mem_rdata : data_q;
        dump_last  = (idx_next == len);
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Scoreboard bench for mips_boot_ctrl: directed sequences push expected memory writes,
// register writes, read addresses and dump words; a negedge monitor pops and compares.
module tb_mips_boot_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        load_valid;
  logic        load_ready;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic        load_last;
  logic        mem_we, mem_re;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        reg_we;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        core_hold, core_pc_load;
  logic [9:0]  core_pc;
  logic        core_halted;
  logic [9:0]  dump_base, dump_len;
  logic        dump_valid, dump_ready;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        busy, done, timeout;

  logic        poke_en;
  logic [9:0]  poke_addr;
  logic [31:0] poke_data;
  logic [31:0] mem [1024];

  int checks = 0;
  int errors = 0;
  int pc_pulses = 0;
  int exp_pc = 0;
  logic prev_pc_load = 1'b0;

  logic [9:0]  exp_wr_addr [$];
  logic [31:0] exp_wr_data [$];
  logic [31:0] exp_reg [$];
  logic [9:0]  exp_rd [$];
  logic [31:0] exp_dd [$];
  logic        exp_dl [$];

  mips_boot_ctrl #(
    .DATA_W(32), .ADDR_W(10), .NUM_REGS(32), .REG_INIT_MODE(1),
    .PC_RESET(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .load_last(load_last),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .core_hold(core_hold), .core_pc_load(core_pc_load), .core_pc(core_pc),
    .core_halted(core_halted), .dump_base(dump_base), .dump_len(dump_len),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_last(dump_last), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we)  mem[mem_addr] <= mem_wdata;
    if (poke_en) mem[poke_addr] <= poke_data;
    if (mem_re)  mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=no-event", name, act);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_pc_load <= 1'b0;
    end else begin
      if (mem_we && mem_re) unexpected("mem_rw_same_cycle", {mem_we, mem_re});
      if (mem_we) begin
        if (exp_wr_addr.size() == 0) unexpected("memwr_extra", mem_addr);
        else begin
          chk("memwr_addr", mem_addr, exp_wr_addr.pop_front());
          chk("memwr_data", mem_wdata, exp_wr_data.pop_front());
        end
      end
      if (reg_we) begin
        if (exp_reg.size() == 0) unexpected("regwr_extra", reg_addr);
        else begin
          chk("regwr_addr", reg_addr, exp_reg[0][4:0]);
          chk("regwr_data", reg_wdata, exp_reg.pop_front());
        end
      end
      if (core_pc_load) begin
        pc_pulses++;
        chk("core_pc", core_pc, 0);
        if (prev_pc_load) unexpected("pc_load_width", 2);
      end
      prev_pc_load <= core_pc_load;
      if (mem_re) begin
        if (exp_rd.size() == 0) unexpected("memrd_extra", mem_addr);
        else chk("memrd_addr", mem_addr, exp_rd.pop_front());
      end
      if (dump_valid) begin
        if (exp_dd.size() == 0) unexpected("dump_extra", dump_data);
        else begin
          chk("dump_data", dump_data, exp_dd[0]);
          chk("dump_last", dump_last, exp_dl[0]);
          if (dump_ready) begin
            void'(exp_dd.pop_front());
            void'(exp_dl.pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    step();
    poke_en = 1'b0;
  endtask

  task automatic start_seq();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load_word(input logic [9:0] a, input logic [31:0] d, input logic last);
    int n = 0;
    exp_wr_addr.push_back(a);
    exp_wr_data.push_back(d);
    load_valid = 1'b1; load_addr = a; load_data = d; load_last = last;
    while (!load_ready && n < 20) begin step(); n++; end
    chk("load_ready", load_ready, 1);
    step();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic push_regs();
    for (int unsigned r = 0; r < 32; r++) exp_reg.push_back(r);
  endtask

  task automatic wait_run();
    int n = 0;
    while (core_hold && n < 100) begin step(); n++; end
    chk("enter_run", core_hold, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin step(); n++; end
    chk("reach_done", done, 1);
  endtask

  task automatic halt(input logic [9:0] b, input logic [9:0] l);
    core_halted = 1'b1; dump_base = b; dump_len = l;
    step();
    core_halted = 1'b0;
    chk("hold_after_halt", core_hold, 1);
  endtask

  task automatic dump_phase(input int stall);
    int n = 0;
    dump_ready = 1'b0;
    while (!dump_valid && n < 20) begin step(); n++; end
    chk("dump_valid_seen", dump_valid, 1);
    repeat (stall) step();
    dump_ready = 1'b1;
    wait_done();
    dump_ready = 1'b0;
  endtask

  task automatic end_of_test(input string tag);
    chk({tag, "_wrq"}, exp_wr_addr.size(), 0);
    chk({tag, "_regq"}, exp_reg.size(), 0);
    chk({tag, "_rdq"}, exp_rd.size(), 0);
    chk({tag, "_dumpq"}, exp_dd.size(), 0);
    chk({tag, "_pc_pulses"}, pc_pulses, exp_pc);
    chk({tag, "_busy"}, busy, 0);
  endtask

  logic [31:0] prog [8] = '{32'h28010078, 32'h0c631800, 32'h20420001, 32'h28630000,
                            32'h0c221800, 32'h14020002, 32'h2c430005, 32'hf0000000};

  initial begin
    reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    load_last = 1'b0; core_halted = 1'b0; dump_base = '0; dump_len = '0;
    dump_ready = 1'b0; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    #2;
    chk("rst_core_hold", core_hold, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_mem_strobes", {mem_we, mem_re, reg_we}, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_pc_load", core_pc_load, 0);
    step();
    reset = 1'b0;
    step();

    // Full program load, stalled two-word dump.
    poke(10'd120, 32'd85);
    poke(10'd121, 32'd130);
    start_seq();
    chk("a_busy", busy, 1);
    push_regs();
    exp_pc++;
    for (int i = 0; i < 8; i++) load_word(10'(i), prog[i], i == 7);
    wait_run();
    exp_rd.push_back(10'd120); exp_rd.push_back(10'd121);
    exp_dd.push_back(32'd85);  exp_dl.push_back(1'b0);
    exp_dd.push_back(32'd130); exp_dl.push_back(1'b1);
    step(); step();
    halt(10'd120, 10'd2);
    dump_phase(5);
    chk("a_timeout", timeout, 0);
    end_of_test("a");

    // Timeout with core never halting.
    start_seq();
    push_regs();
    exp_pc++;
    load_word(10'd8, 32'hf0000000, 1'b1);
    begin
      int run_cycles = 0;
      int n = 0;
      while (!done && n < 100) begin
        step(); n++;
        if (!core_hold) run_cycles++;
      end
      chk("b_run_cycles", run_cycles, 16);
    end
    chk("b_done", done, 1);
    chk("b_timeout", timeout, 1);
    end_of_test("b");

    // Zero-length dump.
    start_seq();
    chk("c_timeout_cleared", timeout, 0);
    chk("c_done_cleared", done, 0);
    push_regs();
    exp_pc++;
    load_word(10'd8, 32'hf0000000, 1'b1);
    wait_run();
    halt(10'd300, 10'd0);
    chk("c_dump_entry_done", done, 0);
    chk("c_dump_entry_re", mem_re, 0);
    step();
    chk("c_done_next", done, 1);
    chk("c_dump_valid", dump_valid, 0);
    chk("c_timeout", timeout, 0);
    end_of_test("c");

    // Dump window wrapping past the top of memory.
    poke(10'd1023, 32'hAAAA0001);
    poke(10'd0, 32'hBBBB0002);
    poke(10'd1, 32'hCCCC0003);
    start_seq();
    push_regs();
    exp_pc++;
    load_word(10'd8, 32'hf0000000, 1'b1);
    wait_run();
    exp_rd.push_back(10'd1023); exp_rd.push_back(10'd0); exp_rd.push_back(10'd1);
    exp_dd.push_back(32'hAAAA0001); exp_dl.push_back(1'b0);
    exp_dd.push_back(32'hBBBB0002); exp_dl.push_back(1'b0);
    exp_dd.push_back(32'hCCCC0003); exp_dl.push_back(1'b1);
    halt(10'd1023, 10'd3);
    dump_phase(0);
    end_of_test("d");

    // Reset in the middle of register init, then a clean rerun.
    start_seq();
    push_regs();
    load_word(10'd8, 32'hf0000000, 1'b1);
    begin
      int n = 0;
      while (!(reg_we && reg_addr == 5'd10) && n < 50) begin step(); n++; end
      chk("e_reach_k10", reg_addr, 10);
    end
    reset = 1'b1;
    #1;
    chk("e_rst_hold", core_hold, 1);
    chk("e_rst_reg_we", reg_we, 0);
    chk("e_rst_reg_addr", reg_addr, 0);
    chk("e_rst_busy", busy, 0);
    chk("e_rst_outs", {load_ready, mem_we, mem_re, dump_valid, done, timeout}, 0);
    exp_reg.delete();
    step();
    reset = 1'b0;
    step();
    poke(10'd40, 32'h12345678);
    start_seq();
    push_regs();
    exp_pc++;
    load_word(10'd8, 32'hf0000000, 1'b1);
    wait_run();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("e_start_in_run_hold", core_hold, 0);
    chk("e_start_in_run_busy", busy, 1);
    exp_rd.push_back(10'd40);
    exp_dd.push_back(32'h12345678); exp_dl.push_back(1'b1);
    halt(10'd40, 10'd1);
    dump_phase(1);
    end_of_test("e");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
